// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the single GPR write port between ALU (port 0) and LSU (port 1).
// Optional anti-starvation for port 0 is enabled by defining WB_ANTISTARVE_EN.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        wb0_valid_i,
    input  logic [4:0]  wb0_rd_i,
    input  logic [31:0] wb0_data_i,
    output logic        wb0_ready_o,
    input  logic        wb1_valid_i,
    input  logic [4:0]  wb1_rd_i,
    input  logic [31:0] wb1_data_i,
    output logic        wb1_ready_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_datord_o,
    output logic        rf_wren_o,
    output logic        inflight_o
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT >= (1 << CNT_W)) begin : g_cfg_check
        $error("rf_wb_arbiter: CNT_W too narrow for STARVE_LIMIT");
    end

    logic        grant0;
    logic        grant1;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    logic        wren_d, wren_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] data_d, data_q;

`ifdef WB_ANTISTARVE_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             starved;

    assign starved = (cnt_q == CNT_W'(STARVE_LIMIT)) && wb0_valid_i;

    // A starved port 0 takes one grant ahead of port 1, then fixed priority resumes.
    always_comb begin
        wb1_ready_o = ~flush_i;
        wb0_ready_o = ~flush_i & ~wb1_valid_i;
        if (starved) begin
            wb0_ready_o = ~flush_i;
            wb1_ready_o = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!wb0_valid_i || grant0) begin
            cnt_d = '0;
        end else if (!flush_i && (cnt_q != CNT_W'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        wb1_ready_o = ~flush_i;
        wb0_ready_o = ~flush_i & ~wb1_valid_i;
    end
`endif

    assign grant0 = wb0_valid_i & wb0_ready_o;
    assign grant1 = wb1_valid_i & wb1_ready_o;

    // Grants are mutually exclusive, so port 1 selection only needs grant1.
    always_comb begin
        sel_rd   = grant1 ? wb1_rd_i   : wb0_rd_i;
        sel_data = grant1 ? wb1_data_i : wb0_data_i;
        wren_d   = (grant0 | grant1) && (sel_rd != 5'd0);
        rd_d     = rd_q;
        data_d   = data_q;
        if (wren_d) begin
            rd_d   = sel_rd;
            data_d = sel_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wren_q <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            wren_q <= wren_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign rf_wren_o   = wren_q;
    assign rf_rd_o     = rd_q;
    assign rf_datord_o = data_q;
    assign inflight_o  = wren_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected register-file writes are queued at
// drive time and popped one cycle later when the output register presents them.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_ni;
    logic        flush_i;
    logic        wb0_valid_i;
    logic [4:0]  wb0_rd_i;
    logic [31:0] wb0_data_i;
    logic        wb0_ready_o;
    logic        wb1_valid_i;
    logic [4:0]  wb1_rd_i;
    logic [31:0] wb1_data_i;
    logic        wb1_ready_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_datord_o;
    logic        rf_wren_o;
    logic        inflight_o;

    rf_wb_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .wb0_valid_i (wb0_valid_i),
        .wb0_rd_i    (wb0_rd_i),
        .wb0_data_i  (wb0_data_i),
        .wb0_ready_o (wb0_ready_o),
        .wb1_valid_i (wb1_valid_i),
        .wb1_rd_i    (wb1_rd_i),
        .wb1_data_i  (wb1_data_i),
        .wb1_ready_o (wb1_ready_o),
        .rf_rd_o     (rf_rd_o),
        .rf_datord_o (rf_datord_o),
        .rf_wren_o   (rf_wren_o),
        .inflight_o  (inflight_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wren;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_cnt;
    int          total;
    int          bad;

    task automatic set_in(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                          input logic fl);
        wb0_valid_i = v0;
        wb0_rd_i    = rd0;
        wb0_data_i  = d0;
        wb1_valid_i = v1;
        wb1_rd_i    = rd1;
        wb1_data_i  = d1;
        flush_i     = fl;
    endtask

    task automatic model_reset();
        m_rd   = '0;
        m_data = '0;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    // Reference arbitration from the current inputs and the model's starvation count.
    task automatic model_eval(output logic r0, output logic r1);
        r1 = !flush_i;
        r0 = !flush_i && !wb1_valid_i;
`ifdef WB_ANTISTARVE_EN
        if (m_cnt == 4 && wb0_valid_i) begin
            r0 = !flush_i;
            r1 = 1'b0;
        end
`endif
    endtask

    task automatic model_push(input logic r0, input logic r1);
        wr_t e;
        logic g0;
        logic g1;
        g0 = wb0_valid_i && r0;
        g1 = wb1_valid_i && r1;
        e.wren = 1'b0;
        if (g1 && wb1_rd_i != 5'd0) begin
            e.wren = 1'b1;
            m_rd   = wb1_rd_i;
            m_data = wb1_data_i;
        end else if (g0 && wb0_rd_i != 5'd0) begin
            e.wren = 1'b1;
            m_rd   = wb0_rd_i;
            m_data = wb0_data_i;
        end
        e.rd   = m_rd;
        e.data = m_data;
        exp_q.push_back(e);
        if (!wb0_valid_i || g0) m_cnt = 0;
        else if (!flush_i && m_cnt < 4) m_cnt = m_cnt + 1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        total++;
        if ({inflight_o, rf_wren_o, rf_rd_o, rf_datord_o} !== 39'd0) begin
            bad++;
            $display("FAIL reset_async got wren=%b rd=%0d data=%h want 0/0/0", rf_wren_o, rf_rd_o, rf_datord_o);
        end
        model_reset();
        @(posedge clk);
        #3 rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({inflight_o, rf_wren_o, rf_rd_o, rf_datord_o} !== 39'd0) begin
                bad++;
                $display("FAIL reset_idle[%0d] got wren=%b rd=%0d data=%h want 0/0/0", i, rf_wren_o, rf_rd_o, rf_datord_o);
            end
        end
    endtask

    task automatic test_single();
        logic er0, er1;
        wr_t  e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) set_in(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
            else        set_in(0, 0, 0, 0, 0, 0, 0);
            #1;
            model_eval(er0, er1);
            total++;
            if ({wb0_ready_o, wb1_ready_o} !== {er0, er1}) begin
                bad++;
                $display("FAIL single_ready[%0d] got %b%b want %b%b", i, wb0_ready_o, wb1_ready_o, er0, er1);
            end
            model_push(er0, er1);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if ({inflight_o, rf_wren_o, rf_rd_o, rf_datord_o} !== {e.wren, e}) begin
                bad++;
                $display("FAIL single_out[%0d] got wren=%b rd=%0d data=%h want wren=%b rd=%0d data=%h",
                         i, rf_wren_o, rf_rd_o, rf_datord_o, e.wren, e.rd, e.data);
            end
            if (i == 0) begin
                total++;
                if ({rf_wren_o, rf_rd_o, rf_datord_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
                    bad++;
                    $display("FAIL single_const got wren=%b rd=%0d data=%h want 1/5/deadbeef", rf_wren_o, rf_rd_o, rf_datord_o);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic er0, er1;
        wr_t  e;
        logic [31:0] want_data [2];
        want_data[0] = 32'h22;
        want_data[1] = 32'h11;
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      set_in(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 0);
            else if (i == 1) set_in(1, 5'd3, 32'h11, 0, 0, 0, 0);
            else             set_in(0, 0, 0, 0, 0, 0, 0);
            #1;
            model_eval(er0, er1);
            total++;
            if ({wb0_ready_o, wb1_ready_o} !== {er0, er1}) begin
                bad++;
                $display("FAIL collide_ready[%0d] got %b%b want %b%b", i, wb0_ready_o, wb1_ready_o, er0, er1);
            end
            model_push(er0, er1);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if ({inflight_o, rf_wren_o, rf_rd_o, rf_datord_o} !== {e.wren, e}) begin
                bad++;
                $display("FAIL collide_out[%0d] got wren=%b rd=%0d data=%h want wren=%b rd=%0d data=%h",
                         i, rf_wren_o, rf_rd_o, rf_datord_o, e.wren, e.rd, e.data);
            end
            if (i < 2) begin
                total++;
                if ({rf_wren_o, rf_rd_o, rf_datord_o} !== {1'b1, 5'd3, want_data[i]}) begin
                    bad++;
                    $display("FAIL collide_order[%0d] got data=%h want %h", i, rf_datord_o, want_data[i]);
                end
            end
        end
    endtask

    task automatic test_x0_discard();
        logic er0, er1;
        wr_t  e;
        set_in(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0);
        #1;
        model_eval(er0, er1);
        total++;
        if (wb1_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL x0_ready got %b want 1", wb1_ready_o);
        end
        model_push(er0, er1);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        total++;
        if ({inflight_o, rf_wren_o, rf_rd_o, rf_datord_o} !== {e.wren, e} || rf_wren_o !== 1'b0) begin
            bad++;
            $display("FAIL x0_out got wren=%b rd=%0d data=%h want wren=0 rd=%0d data=%h",
                     rf_wren_o, rf_rd_o, rf_datord_o, e.rd, e.data);
        end
    endtask

    task automatic test_flush();
        logic er0, er1;
        wr_t  e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      set_in(1, 5'd9, 32'hA5A5A5A5, 0, 0, 0, 0);
            else if (i == 1) set_in(1, 5'd10, 32'h10, 1, 5'd11, 32'h11, 1);
            else             set_in(0, 0, 0, 0, 0, 0, 0);
            #1;
            model_eval(er0, er1);
            total++;
            if ({wb0_ready_o, wb1_ready_o} !== {er0, er1}) begin
                bad++;
                $display("FAIL flush_ready[%0d] got %b%b want %b%b", i, wb0_ready_o, wb1_ready_o, er0, er1);
            end
            model_push(er0, er1);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if ({inflight_o, rf_wren_o, rf_rd_o, rf_datord_o} !== {e.wren, e}) begin
                bad++;
                $display("FAIL flush_out[%0d] got wren=%b rd=%0d data=%h want wren=%b rd=%0d data=%h",
                         i, rf_wren_o, rf_rd_o, rf_datord_o, e.wren, e.rd, e.data);
            end
            if (i == 1) begin
                total++;
                if ({rf_wren_o, rf_rd_o, rf_datord_o} !== {1'b0, 5'd9, 32'hA5A5A5A5}) begin
                    bad++;
                    $display("FAIL flush_hold got wren=%b rd=%0d data=%h want 0/9/a5a5a5a5", rf_wren_o, rf_rd_o, rf_datord_o);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        set_in(0, 0, 0, 1, 5'd12, 32'h1234, 0);
        @(posedge clk);
        #1;
        total++;
        if (rf_wren_o !== 1'b1 || rf_rd_o !== 5'd12) begin
            bad++;
            $display("FAIL midop_pre got wren=%b rd=%0d want 1/12", rf_wren_o, rf_rd_o);
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        total++;
        if ({inflight_o, rf_wren_o, rf_rd_o, rf_datord_o} !== 39'd0) begin
            bad++;
            $display("FAIL midop_reset got wren=%b rd=%0d data=%h want 0/0/0", rf_wren_o, rf_rd_o, rf_datord_o);
        end
        #1 rst_ni = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_starve();
        logic er0, er1;
        wr_t  e;
        logic [6:0] want_r0;
`ifdef WB_ANTISTARVE_EN
        want_r0 = 7'b0010000;
`else
        want_r0 = 7'b0000000;
`endif
        for (int i = 0; i < 7; i++) begin
            set_in(1, 5'd20, 32'hA000 + i, 1, 5'(i + 1), 32'hB000 + i, 0);
            #1;
            model_eval(er0, er1);
            total++;
            if ({wb0_ready_o, wb1_ready_o} !== {want_r0[i], ~want_r0[i]} ||
                {wb0_ready_o, wb1_ready_o} !== {er0, er1}) begin
                bad++;
                $display("FAIL starve_ready[%0d] got %b%b want %b%b", i, wb0_ready_o, wb1_ready_o, want_r0[i], ~want_r0[i]);
            end
            model_push(er0, er1);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if ({inflight_o, rf_wren_o, rf_rd_o, rf_datord_o} !== {e.wren, e}) begin
                bad++;
                $display("FAIL starve_out[%0d] got wren=%b rd=%0d data=%h want wren=%b rd=%0d data=%h",
                         i, rf_wren_o, rf_rd_o, rf_datord_o, e.wren, e.rd, e.data);
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_ni = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_single();
        test_collision();
        test_x0_discard();
        test_flush();
        test_reset_midop();
        test_back_to_back_starve();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-port arbiter and sequencer for the 32x32 GPR register file, which has 1 write port and 2 combinational read ports.
- Shares the single write port between two writeback requesters: port 0 (ALU) and port 1 (LSU load return).
- Registers the winning write onto the regfile write bus (rd/datord/wren) and discards writes to x0.
- Exports an in-flight indication so the issue stage can stall on read-after-write.

Parameters:
- STARVE_LIMIT, 4, consecutive lost cycles on port 0 before priority inverts for one grant (only used with WB_ANTISTARVE_EN).
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush; suppresses grants.
- wb0_valid_i  in  1  port 0 write request.
- wb0_rd_i  in  5  port 0 destination register.
- wb0_data_i  in  32  port 0 write data.
- wb0_ready_o  out  1  port 0 accepted this cycle.
- wb1_valid_i  in  1  port 1 write request.
- wb1_rd_i  in  5  port 1 destination register.
- wb1_data_i  in  32  port 1 write data.
- wb1_ready_o  out  1  port 1 accepted this cycle.
- rf_rd_o  out  5  to regfile rd_i.
- rf_datord_o  out  32  to regfile datord_i.
- rf_wren_o  out  1  to regfile wren_i.
- inflight_o  out  1  a write is latched but not yet committed to the GPR array (equals rf_wren_o).

Behaviour:
- Reset (rst_ni=0, async): rf_rd_o=0, rf_datord_o=0, rf_wren_o=0, starvation counter=0.
- Handshake: transfer occurs when valid and ready are both 1 in the same cycle.
  - ready is combinational from valid, flush_i and the counter.
  - Requesters hold rd/data stable while valid and not ready.
- Arbitration, base rule: fixed priority, port 1 over port 0.
  - wb1_ready_o = ~flush_i.
  - wb0_ready_o = ~flush_i & ~wb1_valid_i.
  - Only one grant per cycle.
- flush_i=1: both ready=0, no transfer. At the next edge rf_wren_o<=0; rd/data hold.
- Output register:
  - On edge with a grant and granted rd!=0: rf_wren_o<=1 and rf_rd_o/rf_datord_o latch the granted request.
  - Otherwise rf_wren_o<=0 and rf_rd_o/rf_datord_o hold.
- Latency: accepted in cycle t; rf_wren_o high in cycle t+1; GPR updated at edge ending t+1. The regfile never stalls, so the output stage drains every cycle and there is no backpressure from the regfile side.
- rd=0: handshake completes (ready=1) but the write is dropped; rf_wren_o<=0 at the next edge.
- Both ports valid with the same rd: port 1 commits first, port 0 commits a cycle later. Last writer wins, giving program order LSU then ALU.
- inflight_o = rf_wren_o. The issue stage compares rs1/rs2 against rf_rd_o to stall or bypass.
- Reset asserted mid-operation: the pending write is lost (rf_wren_o forced to 0 immediately). Requesters must re-present after reset.

Optional Feature:
- Macro: WB_ANTISTARVE_EN.
- Defined:
  - Counter increments each cycle wb0_valid_i=1 & wb0_ready_o=0 & flush_i=0, saturating at STARVE_LIMIT.
  - When counter==STARVE_LIMIT and wb0_valid_i=1: wb0_ready_o=~flush_i, wb1_ready_o=0 (port 0 wins).
  - Counter clears on any port 0 grant or when wb0_valid_i=0.
- Undefined: counter absent; pure fixed priority as above; STARVE_LIMIT unused.

Test Plan:
1. Reset then idle: rst_ni low, then high; all valid=0 -> rf_wren_o=0, rf_rd_o=0, rf_datord_o=0 for 5 cycles.
2. Single write: wb0_valid_i=1, rd=5, data=0xDEADBEEF for 1 cycle -> wb0_ready_o=1; next cycle rf_wren_o=1, rf_rd_o=5, rf_datord_o=0xDEADBEEF; following cycle rf_wren_o=0.
3. Collision: both valid, rd0=3/0x11, rd1=3/0x22 -> cycle t: wb1_ready_o=1, wb0_ready_o=0; t+1: writes rd 3 with 0x22; t+2: writes rd 3 with 0x11.
4. x0 discard: wb1_valid_i=1, rd=0, data=0xFFFFFFFF -> wb1_ready_o=1; rf_wren_o stays 0.
5. Flush: flush_i=1 with both valid -> both ready=0, rf_wren_o=0 next cycle. Async reset pulse while rf_wren_o=1 -> rf_wren_o drops immediately.
6. With WB_ANTISTARVE_EN, STARVE_LIMIT=4: both valid continuously -> port 1 granted 4 cycles, port 0 granted cycle 5, then port 1 resumes.
